// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared pipeline constants and slot-update decode for EX/MEM
package ex_mem_reg_pkg;

    localparam int REG_BUS_W        = 32;
    localparam int REG_ADDR_BUS_W   = 5;
    localparam int ALU_OP_BUS_W     = 8;
    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int STALL_W          = 6;
    localparam int EX_STALL_BIT     = 3;
    localparam int MEM_STALL_BIT    = 4;

    localparam logic                      RST_ENABLE   = 1'b1;
    localparam logic                      STOP         = 1'b1;
    localparam logic                      NO_STOP      = 1'b0;
    localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [ALU_OP_BUS_W-1:0]   EXE_NOP_OP   = 8'h00;

    typedef enum logic [1:0] {
        SLOT_BUBBLE,
        SLOT_HOLD,
        SLOT_CAPTURE,
        SLOT_ADVANCE
    } slot_act_e;

    // Flush beats a memory stall; a memory stall beats an execute stall.
    function automatic slot_act_e slot_action(input logic flush, input logic mem_stall,
                                              input logic ex_stall);
        if (flush)
            return SLOT_BUBBLE;
        else if (mem_stall == STOP)
            return SLOT_HOLD;
        else if (ex_stall == STOP)
            return SLOT_CAPTURE;
        else
            return SLOT_ADVANCE;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - execute-to-memory pipeline register with multi-cycle intermediate hold
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W        = REG_BUS_W,
    parameter int REG_ADDR_W    = REG_ADDR_BUS_W,
    parameter int ALUOP_W       = ALU_OP_BUS_W,
    parameter int STALL_W_P     = STALL_W,
    parameter int EX_STALL_IDX  = EX_STALL_BIT,
    parameter int MEM_STALL_IDX = MEM_STALL_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W_P-1:0]  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic [REG_ADDR_W-1:0] wd_d, wd_q;
    logic                  wreg_d, wreg_q;
    logic [DATA_W-1:0]     wdata_d, wdata_q;
    logic [DATA_W-1:0]     hi_d, hi_q;
    logic [DATA_W-1:0]     lo_d, lo_q;
    logic                  whilo_d, whilo_q;
    logic [ALUOP_W-1:0]    aluop_d, aluop_q;
    logic [DATA_W-1:0]     addr_d, addr_q;
    logic [DATA_W-1:0]     reg2_d, reg2_q;
    logic [2*DATA_W-1:0]   hilo_d, hilo_q;
    logic [1:0]            cnt_d, cnt_q;

    slot_act_e act;
    logic      unused_stall_bits;

    assign unused_stall_bits = ^stall;
    assign act = slot_action(flush, stall[MEM_STALL_IDX], stall[EX_STALL_IDX]);

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        aluop_d = aluop_q;
        addr_d  = addr_q;
        reg2_d  = reg2_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        if (act == SLOT_BUBBLE || act == SLOT_CAPTURE) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            whilo_d = 1'b0;
            aluop_d = '0;
            addr_d  = '0;
            reg2_d  = '0;
        end else if (act == SLOT_ADVANCE) begin
            wd_d    = ex_wd;
            wreg_d  = ex_wreg;
            wdata_d = ex_wdata;
            hi_d    = ex_hi;
            lo_d    = ex_lo;
            whilo_d = ex_whilo;
            aluop_d = ex_aluop;
            addr_d  = ex_mem_addr;
            reg2_d  = ex_reg2;
        end
        // The intermediate survives only while execute is stalled on its own.
        if (act == SLOT_CAPTURE) begin
            hilo_d = hilo_i;
            cnt_d  = cnt_i;
        end else if (act != SLOT_HOLD) begin
            hilo_d = '0;
            cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= 1'b0;
            aluop_q <= '0;
            addr_q  <= '0;
            reg2_q  <= '0;
            hilo_q  <= '0;
            cnt_q   <= 2'd0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            reg2_q  <= reg2_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd       = wd_q;
    assign mem_wreg     = wreg_q;
    assign mem_wdata    = wdata_q;
    assign mem_hi       = hi_q;
    assign mem_lo       = lo_q;
    assign mem_whilo    = whilo_q;
    assign mem_aluop    = aluop_q;
    assign mem_mem_addr = addr_q;
    assign mem_reg2     = reg2_q;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - table-driven scoreboard bench for ex_mem_reg
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
    } slot_t;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        slot_t       ex;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
    } stim_t;

    typedef struct packed {
        slot_t       mem;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } resp_t;

    typedef struct packed {
        stim_t stim;
        resp_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_reg2 = '0;
    logic        ex_whilo = 1'b0;
    logic [7:0]  ex_aluop = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  vecs[$];
    resp_t sb[$];

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    function automatic slot_t mk_slot(input logic [4:0] wd, input logic wreg, input logic [31:0] d);
        slot_t s;
        s.wd    = wd;
        s.wreg  = wreg;
        s.wdata = d;
        s.hi    = d ^ 32'h1111_1111;
        s.lo    = ~d;
        s.whilo = wreg;
        s.aluop = {3'b001, wd};
        s.addr  = d + 32'd4;
        s.reg2  = {d[30:0], 1'b0};
        return s;
    endfunction

    function automatic void add(input logic r, input logic f, input logic [5:0] st,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] d,
                                input logic [63:0] hi_in, input logic [1:0] c_in,
                                input slot_t exp_mem, input logic [63:0] exp_hilo,
                                input logic [1:0] exp_cnt);
        vec_t v;
        v.stim.rst    = r;
        v.stim.flush  = f;
        v.stim.stall  = st;
        v.stim.ex     = mk_slot(wd, wreg, d);
        v.stim.hilo_i = hi_in;
        v.stim.cnt_i  = c_in;
        v.exp.mem     = exp_mem;
        v.exp.hilo    = exp_hilo;
        v.exp.cnt     = exp_cnt;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs(input string tag);
        resp_t e, got;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].stim.rst;
            flush       = vecs[i].stim.flush;
            stall       = vecs[i].stim.stall;
            ex_wd       = vecs[i].stim.ex.wd;
            ex_wreg     = vecs[i].stim.ex.wreg;
            ex_wdata    = vecs[i].stim.ex.wdata;
            ex_hi       = vecs[i].stim.ex.hi;
            ex_lo       = vecs[i].stim.ex.lo;
            ex_whilo    = vecs[i].stim.ex.whilo;
            ex_aluop    = vecs[i].stim.ex.aluop;
            ex_mem_addr = vecs[i].stim.ex.addr;
            ex_reg2     = vecs[i].stim.ex.reg2;
            hilo_i      = vecs[i].stim.hilo_i;
            cnt_i       = vecs[i].stim.cnt_i;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got.mem = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
                        mem_mem_addr, mem_reg2};
            got.hilo = hilo_o;
            got.cnt  = cnt_o;
            e = sb.pop_front();
            n_tests++;
            if (got.mem !== e.mem) begin
                n_fail++;
                $display("FAIL %s[%0d] mem_slot got=%h exp=%h", tag, i, got.mem, e.mem);
            end
            n_tests++;
            if (got.hilo !== e.hilo || got.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s[%0d] hilo/cnt got=%h/%0d exp=%h/%0d",
                         tag, i, got.hilo, got.cnt, e.hilo, e.cnt);
            end
        end
        vecs.delete();
    endtask

    localparam logic [63:0] P1 = 64'h1234_5678_9ABC_DEF0;

    initial begin
        slot_t bub, a5, s13;
        bub = '0;
        a5  = mk_slot(5'd7, 1'b1, 32'hA5A5_A5A5);
        s13 = mk_slot(5'd13, 1'b1, 32'h0000_0013);

        // reset, advance, EX-stall capture, MEM hold, flush over stall, odd stall patterns
        add(1, 0, 6'b000000, 5'd3,  1, 32'hDEAD_BEEF, 64'h5,  2'd2, bub, 64'h0, 2'd0);
        add(1, 0, 6'b000000, 5'd3,  1, 32'hDEAD_BEEF, 64'h5,  2'd2, bub, 64'h0, 2'd0);
        add(0, 0, 6'b000000, 5'd8,  1, 32'h0000_00FF, 64'h77, 2'd3,
            mk_slot(5'd8, 1, 32'h0000_00FF), 64'h0, 2'd0);
        add(0, 0, 6'b001111, 5'd9,  1, 32'h0000_0055, P1,     2'd1, bub, P1, 2'd1);
        add(0, 0, 6'b000000, 5'd10, 1, 32'h0000_1000, P1,     2'd2,
            mk_slot(5'd10, 1, 32'h0000_1000), 64'h0, 2'd0);
        add(0, 0, 6'b000000, 5'd7,  1, 32'hA5A5_A5A5, 64'h0,  2'd0, a5, 64'h0, 2'd0);
        add(0, 0, 6'b011111, 5'd1,  1, 32'h0000_0001, 64'hFF, 2'd3, a5, 64'h0, 2'd0);
        add(0, 0, 6'b011111, 5'd2,  0, 32'h0000_0002, 64'hFE, 2'd2, a5, 64'h0, 2'd0);
        add(0, 0, 6'b011111, 5'd3,  1, 32'h0000_0003, 64'hFD, 2'd1, a5, 64'h0, 2'd0);
        add(0, 1, 6'b011111, 5'd4,  1, 32'h0000_0004, 64'hFC, 2'd1, bub, 64'h0, 2'd0);
        add(0, 0, 6'b000000, 5'd12, 0, 32'h0000_CAFE, 64'h1,  2'd1,
            mk_slot(5'd12, 0, 32'h0000_CAFE), 64'h0, 2'd0);
        add(0, 0, 6'b000111, 5'd13, 1, 32'h0000_0013, 64'h2,  2'd2, s13, 64'h0, 2'd0);
        add(0, 0, 6'b010000, 5'd14, 1, 32'h0000_0014, 64'h3,  2'd3, s13, 64'h0, 2'd0);
        add(0, 1, 6'b000000, 5'd15, 1, 32'h0000_0015, 64'h4,  2'd1, bub, 64'h0, 2'd0);
        run_vecs("table");

        // multi-cycle op walk 0->1->2, held under a memory stall, then reset mid-op
        add(0, 0, 6'b001111, 5'd5, 1, 32'h0000_0101, 64'hABCD, 2'd1, bub, 64'hABCD, 2'd1);
        add(0, 0, 6'b011111, 5'd5, 1, 32'h0000_0101, 64'h9999, 2'd2, bub, 64'hABCD, 2'd1);
        add(0, 0, 6'b001111, 5'd5, 1, 32'h0000_0101, 64'hBEEF, 2'd2, bub, 64'hBEEF, 2'd2);
        add(1, 0, 6'b001111, 5'd5, 1, 32'h0000_0101, 64'hCAFE, 2'd3, bub, 64'h0,    2'd0);
        run_vecs("mc_reset");

        // flush during execute stall discards the intermediate
        add(0, 0, 6'b001111, 5'd6, 1, 32'h0000_0202, P1,       2'd1, bub, P1, 2'd1);
        add(0, 1, 6'b001111, 5'd6, 1, 32'h0000_0202, 64'h5555, 2'd2, bub, 64'h0, 2'd0);
        add(0, 0, 6'b000000, 5'd6, 1, 32'h0000_0202, 64'h5555, 2'd2,
            mk_slot(5'd6, 1, 32'h0000_0202), 64'h0, 2'd0);
        run_vecs("mc_flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
